// File: rtl/ex_mem_stage.sv
// Execute stage with the EX/MEM pipeline register.
// Computes the ALU result, maintains the sticky N/Z flags, resolves
// register-target branches/jumps, and registers everything MEM/WB need.
// Supports hazard-unit stall (hold) and flush (bubble).
module ex_mem_stage #(
    parameter int DW = 32,
    parameter int RW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          valid_in,
    input  logic          branchN,
    input  logic          branchZ,
    input  logic          jump,
    input  logic          jumpMem,
    input  logic          memRead,
    input  logic          memToReg,
    input  logic          memWrite,
    input  logic          pcReg,
    input  logic [3:0]    aluOp,
    input  logic          regWrt,
    input  logic [RW-1:0] rd,
    input  logic [DW-1:0] rs,
    input  logic [DW-1:0] rt,
    input  logic [DW-1:0] adder,
    output logic          valid_out,
    output logic          memReadout,
    output logic          memToRegout,
    output logic          memWriteout,
    output logic          jumpMemout,
    output logic          regWrtout,
    output logic [RW-1:0] rdOut,
    output logic [DW-1:0] aluOut,
    output logic [DW-1:0] rtOut,
    output logic [DW-1:0] rsOut,
    output logic          takenOut,
    output logic [DW-1:0] targetOut,
    output logic          nFlag,
    output logic          zFlag
);

    logic          r_valid;
    logic          r_mem_read;
    logic          r_mem_to_reg;
    logic          r_mem_write;
    logic          r_jump_mem;
    logic          r_reg_wrt;
    logic [RW-1:0] r_rd;
    logic [DW-1:0] r_alu;
    logic [DW-1:0] r_rt;
    logic [DW-1:0] r_rs;
    logic          r_taken;
    logic [DW-1:0] r_target;
    logic          r_n;
    logic          r_z;

    logic [DW-1:0] w_alu_raw;
    logic [DW-1:0] w_result;
    logic          w_taken;
    logic          w_load;
    logic          w_flag_op;

    // ALU operation select; pcReg overrides with the PC-relative value.
    always_comb begin
        w_alu_raw = '0;
        case (aluOp)
            4'd0:    w_alu_raw = rs;
            4'd1:    w_alu_raw = rs + rt;
            4'd2:    w_alu_raw = rs - rt;
            4'd3:    w_alu_raw = '0 - rs;
            4'd4:    w_alu_raw = rs & rt;
            4'd5:    w_alu_raw = rs | rt;
            4'd6:    w_alu_raw = rs ^ rt;
            4'd7:    w_alu_raw = rt;
            default: w_alu_raw = '0;
        endcase
        w_result = pcReg ? adder : w_alu_raw;
    end

    // Branch decision uses the currently stored flags (pre-update values).
    assign w_taken   = valid_in & (jump | (branchZ & r_z) | (branchN & r_n));
    // A real instruction is loaded only when neither held nor flushed.
    assign w_load    = ~stall & ~flush & valid_in;
    // Only arithmetic/logic ops 1..6 produce flags; pcReg results never do.
    assign w_flag_op = ~pcReg & (aluOp >= 4'd1) & (aluOp <= 4'd6);

    // Pipeline register: reset > stall (hold) > flush/invalid (bubble) > load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_mem_write  <= 1'b0;
            r_jump_mem   <= 1'b0;
            r_reg_wrt    <= 1'b0;
            r_rd         <= '0;
            r_alu        <= '0;
            r_rt         <= '0;
            r_rs         <= '0;
            r_taken      <= 1'b0;
            r_target     <= '0;
        end else if (!stall) begin
            if (w_load) begin
                r_valid      <= 1'b1;
                r_mem_read   <= memRead;
                r_mem_to_reg <= memToReg;
                r_mem_write  <= memWrite;
                r_jump_mem   <= jumpMem;
                r_reg_wrt    <= regWrt;
                r_rd         <= rd;
                r_alu        <= w_result;
                r_rt         <= rt;
                r_rs         <= rs;
                r_taken      <= w_taken;
                r_target     <= w_taken ? rs : '0;
            end else begin
                r_valid      <= 1'b0;
                r_mem_read   <= 1'b0;
                r_mem_to_reg <= 1'b0;
                r_mem_write  <= 1'b0;
                r_jump_mem   <= 1'b0;
                r_reg_wrt    <= 1'b0;
                r_rd         <= '0;
                r_alu        <= '0;
                r_rt         <= '0;
                r_rs         <= '0;
                r_taken      <= 1'b0;
                r_target     <= '0;
            end
        end
    end

    // Sticky condition flags, written only by flag-producing real loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n <= 1'b0;
            r_z <= 1'b0;
        end else if (w_load && w_flag_op) begin
            r_n <= w_alu_raw[DW-1];
            r_z <= (w_alu_raw == '0);
        end
    end

    assign valid_out   = r_valid;
    assign memReadout  = r_mem_read;
    assign memToRegout = r_mem_to_reg;
    assign memWriteout = r_mem_write;
    assign jumpMemout  = r_jump_mem;
    assign regWrtout   = r_reg_wrt;
    assign rdOut       = r_rd;
    assign aluOut      = r_alu;
    assign rtOut       = r_rt;
    assign rsOut       = r_rs;
    assign takenOut    = r_taken;
    assign targetOut   = r_target;
    assign nFlag       = r_n;
    assign zFlag       = r_z;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: a reference model pushes expected
// EX/MEM contents into a scoreboard queue each cycle; tasks pop and compare.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, valid_in;
    logic        branchN, branchZ, jump, jumpMem;
    logic        memRead, memToReg, memWrite, pcReg, regWrt;
    logic [3:0]  aluOp;
    logic [5:0]  rd;
    logic [31:0] rs, rt, adder;
    logic        valid_out, memReadout, memToRegout, memWriteout, jumpMemout, regWrtout;
    logic [5:0]  rdOut;
    logic [31:0] aluOut, rtOut, rsOut, targetOut;
    logic        takenOut, nFlag, zFlag;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        v, mr, mtr, mw, jm, rw;
        logic [5:0]  rd;
        logic [31:0] alu, rt, rs;
        logic        tk;
        logic [31:0] tg;
        logic        n, z;
    } exp_t;

    exp_t m;
    exp_t q[$];
    exp_t e;

    ex_mem_stage #(.DW(32), .RW(6)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
        .branchN(branchN), .branchZ(branchZ), .jump(jump), .jumpMem(jumpMem),
        .memRead(memRead), .memToReg(memToReg), .memWrite(memWrite), .pcReg(pcReg),
        .aluOp(aluOp), .regWrt(regWrt), .rd(rd), .rs(rs), .rt(rt), .adder(adder),
        .valid_out(valid_out), .memReadout(memReadout), .memToRegout(memToRegout),
        .memWriteout(memWriteout), .jumpMemout(jumpMemout), .regWrtout(regWrtout),
        .rdOut(rdOut), .aluOut(aluOut), .rtOut(rtOut), .rsOut(rsOut),
        .takenOut(takenOut), .targetOut(targetOut), .nFlag(nFlag), .zFlag(zFlag)
    );

    always #5 clk = ~clk;

    function automatic exp_t obs();
        exp_t o;
        o = '{valid_out, memReadout, memToRegout, memWriteout, jumpMemout, regWrtout,
              rdOut, aluOut, rtOut, rsOut, takenOut, targetOut, nFlag, zFlag};
        return o;
    endfunction

    // Reference model of one clock edge given the current inputs.
    function automatic exp_t model_next(exp_t cur);
        exp_t nx;
        logic [31:0] r;
        if (stall) return cur;
        nx = '0;
        nx.n = cur.n;
        nx.z = cur.z;
        if (flush || !valid_in) return nx;
        case (aluOp)
            4'd0: r = rs;
            4'd1: r = rs + rt;
            4'd2: r = rs - rt;
            4'd3: r = 32'd0 - rs;
            4'd4: r = rs & rt;
            4'd5: r = rs | rt;
            4'd6: r = rs ^ rt;
            4'd7: r = rt;
            default: r = 32'd0;
        endcase
        nx.v = 1'b1; nx.mr = memRead; nx.mtr = memToReg; nx.mw = memWrite;
        nx.jm = jumpMem; nx.rw = regWrt; nx.rd = rd; nx.rt = rt; nx.rs = rs;
        nx.alu = pcReg ? adder : r;
        nx.tk = jump | (branchZ & cur.z) | (branchN & cur.n);
        nx.tg = nx.tk ? rs : 32'd0;
        if (!pcReg && aluOp >= 4'd1 && aluOp <= 4'd6) begin
            nx.n = r[31];
            nx.z = (r == 32'd0);
        end
        return nx;
    endfunction

    task automatic clear_in();
        stall = 0; flush = 0; valid_in = 0; branchN = 0; branchZ = 0; jump = 0;
        jumpMem = 0; memRead = 0; memToReg = 0; memWrite = 0; pcReg = 0;
        regWrt = 0; aluOp = 0; rd = 0; rs = 0; rt = 0; adder = 0;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        clear_in();
        valid_in = 1; regWrt = 1; rd = 6'd3; aluOp = op; rs = a; rt = b;
    endtask

    // Push the model's prediction for this edge, then advance past the edge.
    task automatic cycle();
        m = model_next(m);
        q.push_back(m);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'($urandom); flush = 1'($urandom); valid_in = 1;
        branchN = 1; branchZ = 1; jump = 1; jumpMem = 1; memRead = 1; memToReg = 1;
        memWrite = 1; pcReg = 0; regWrt = 1; aluOp = 4'($urandom);
        rd = 6'($urandom); rs = $urandom; rt = $urandom; adder = $urandom;
        repeat (3) @(posedge clk);
        #1;
        m = '0;
        q.delete();
        checks++;
        if (obs() !== '0) begin
            errors++; $display("FAIL reset_hold got=%h exp=0", obs());
        end
        set_op(4'd7, 32'h0, 32'hABCD);
        rst_n = 1'b1;
        #2;
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL reset_release_early valid_out=%b exp=0", valid_out);
        end
        cycle();
        e = q.pop_front();
        checks++;
        if (obs() !== e || aluOut !== 32'hABCD || valid_out !== 1'b1) begin
            errors++; $display("FAIL reset_first_load got=%h exp=%h", obs(), e);
        end
        $display("reset: first load aluOut=%h", aluOut);
    endtask

    task automatic test_alu();
        set_op(4'd1, 32'h7FFFFFFF, 32'h1);
        cycle();
        e = q.pop_front();
        checks++;
        if (obs() !== e || aluOut !== 32'h80000000 || nFlag !== 1'b1 || zFlag !== 1'b0) begin
            errors++; $display("FAIL add_overflow aluOut=%h n=%b z=%b exp=80000000 1 0", aluOut, nFlag, zFlag);
        end
        $display("alu: add aluOut=%h n=%b z=%b", aluOut, nFlag, zFlag);
        set_op(4'd2, 32'd5, 32'd5);
        cycle();
        e = q.pop_front();
        checks++;
        if (obs() !== e || aluOut !== 32'h0 || nFlag !== 1'b0 || zFlag !== 1'b1) begin
            errors++; $display("FAIL sub_zero aluOut=%h n=%b z=%b exp=0 0 1", aluOut, nFlag, zFlag);
        end
        $display("alu: sub aluOut=%h n=%b z=%b", aluOut, nFlag, zFlag);
        set_op(4'd3, 32'd1, 32'd0);
        cycle();
        e = q.pop_front();
        checks++;
        if (aluOut !== 32'hFFFFFFFF || nFlag !== 1'b1) begin
            errors++; $display("FAIL negate aluOut=%h n=%b exp=ffffffff 1", aluOut, nFlag);
        end
        for (int op = 0; op < 16; op++) begin
            set_op(4'(op), $urandom, $urandom);
            cycle();
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++; $display("FAIL alu_op%0d got=%h exp=%h", op, obs(), e);
            end
            $display("alu: op=%0d aluOut=%h", op, aluOut);
        end
    endtask

    task automatic test_branch();
        set_op(4'd2, 32'd9, 32'd9);          // sets Z
        cycle();
        void'(q.pop_front());
        set_op(4'd0, 32'h40, 32'd0);
        branchZ = 1;
        cycle();
        e = q.pop_front();
        checks++;
        if (obs() !== e || takenOut !== 1'b1 || targetOut !== 32'h40) begin
            errors++; $display("FAIL branchz_taken taken=%b target=%h exp=1 40", takenOut, targetOut);
        end
        $display("branch: z taken=%b target=%h", takenOut, targetOut);
        set_op(4'd1, 32'd1, 32'd0);          // clears Z
        cycle();
        void'(q.pop_front());
        set_op(4'd0, 32'h40, 32'd0);
        branchZ = 1;
        cycle();
        e = q.pop_front();
        checks++;
        if (obs() !== e || takenOut !== 1'b0 || targetOut !== 32'h0) begin
            errors++; $display("FAIL branchz_not_taken taken=%b target=%h exp=0 0", takenOut, targetOut);
        end
        $display("branch: nz taken=%b target=%h", takenOut, targetOut);
        set_op(4'd0, 32'h10, 32'd0);
        jump = 1; jumpMem = 1;
        cycle();
        e = q.pop_front();
        checks++;
        if (obs() !== e || takenOut !== 1'b1 || targetOut !== 32'h10 || jumpMemout !== 1'b1) begin
            errors++; $display("FAIL jump taken=%b target=%h jm=%b exp=1 10 1", takenOut, targetOut, jumpMemout);
        end
        $display("branch: jump taken=%b target=%h", takenOut, targetOut);
        // Old flags (Z=0) decide the branch; the same SUB then sets Z.
        set_op(4'd2, 32'h20, 32'h20);
        branchZ = 1;
        cycle();
        e = q.pop_front();
        checks++;
        if (obs() !== e || takenOut !== 1'b0 || zFlag !== 1'b1) begin
            errors++; $display("FAIL branch_old_flags taken=%b z=%b exp=0 1", takenOut, zFlag);
        end
        $display("branch: same-op taken=%b z=%b", takenOut, zFlag);
    endtask

    task automatic test_stall_flush();
        exp_t held;
        set_op(4'd1, 32'h100, 32'h23);
        cycle();
        void'(q.pop_front());
        held = obs();
        for (int i = 0; i < 2; i++) begin
            set_op(4'd2, $urandom, $urandom);
            stall = 1;
            cycle();
            e = q.pop_front();
            checks++;
            if (obs() !== e || aluOut !== 32'h123) begin
                errors++; $display("FAIL stall_hold%0d got=%h exp=%h", i, obs(), e);
            end
            $display("stall: aluOut=%h", aluOut);
        end
        set_op(4'd6, $urandom, $urandom);
        stall = 1; flush = 1;
        cycle();
        e = q.pop_front();
        checks++;
        if (obs() !== held) begin
            errors++; $display("FAIL stall_flush got=%h exp=%h", obs(), held);
        end
        set_op(4'd2, 32'd7, 32'd7);
        flush = 1;
        cycle();
        e = q.pop_front();
        checks++;
        if (obs() !== e || valid_out !== 1'b0 || regWrtout !== 1'b0 || aluOut !== 32'h0 ||
            nFlag !== held.n || zFlag !== held.z) begin
            errors++; $display("FAIL flush_bubble got=%h exp=%h", obs(), e);
        end
        $display("flush: valid_out=%b aluOut=%h", valid_out, aluOut);
    endtask

    task automatic test_pcreg_wrap();
        logic n0, z0;
        n0 = nFlag; z0 = zFlag;
        set_op(4'd1, 32'h7FFFFFFF, 32'h1);
        pcReg = 1; adder = 32'h1234;
        cycle();
        e = q.pop_front();
        checks++;
        if (obs() !== e || aluOut !== 32'h1234 || nFlag !== n0 || zFlag !== z0) begin
            errors++; $display("FAIL pcreg aluOut=%h n=%b z=%b exp=1234 %b %b", aluOut, nFlag, zFlag, n0, z0);
        end
        $display("pcreg: aluOut=%h", aluOut);
        set_op(4'd1, 32'hFFFFFFFF, 32'h1);
        cycle();
        e = q.pop_front();
        checks++;
        if (obs() !== e || aluOut !== 32'h0 || zFlag !== 1'b1 || nFlag !== 1'b0) begin
            errors++; $display("FAIL wrap aluOut=%h z=%b exp=0 1", aluOut, zFlag);
        end
        $display("wrap: aluOut=%h z=%b", aluOut, zFlag);
    endtask

    task automatic test_bubble();
        set_op(4'd1, 32'h3, 32'h3);
        valid_in = 0; jump = 1; regWrt = 1;
        cycle();
        e = q.pop_front();
        checks++;
        if (obs() !== e || valid_out !== 1'b0 || regWrtout !== 1'b0 || takenOut !== 1'b0) begin
            errors++; $display("FAIL invalid_bubble got=%h exp=%h", obs(), e);
        end
        $display("bubble: valid_out=%b taken=%b", valid_out, takenOut);
    endtask

    task automatic test_reset_mid_stall();
        set_op(4'd5, 32'hF0, 32'h0F);
        cycle();
        void'(q.pop_front());
        stall = 1;
        cycle();
        void'(q.pop_front());
        #2;
        rst_n = 0;
        #1;
        m = '0;
        checks++;
        if (obs() !== '0) begin
            errors++; $display("FAIL reset_mid_stall got=%h exp=0", obs());
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        clear_in();
        cycle();
        e = q.pop_front();
        checks++;
        if (obs() !== e || valid_out !== 1'b0) begin
            errors++; $display("FAIL after_reset_stall got=%h exp=%h", obs(), e);
        end
        $display("reset mid-stall: valid_out=%b", valid_out);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 200; i++) begin
            set_op(4'($urandom_range(0, 15)), $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) rs = 32'd0;
            valid_in = ($urandom_range(0, 7) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            branchN  = 1'($urandom); branchZ = 1'($urandom);
            jump     = ($urandom_range(0, 5) == 0);
            jumpMem  = 1'($urandom); memRead = 1'($urandom);
            memToReg = 1'($urandom); memWrite = 1'($urandom);
            pcReg    = ($urandom_range(0, 5) == 0);
            regWrt   = 1'($urandom); rd = 6'($urandom); adder = $urandom;
            cycle();
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++; $display("FAIL b2b_%0d got=%h exp=%h", i, obs(), e);
            end
            $display("b2b %0d: v=%b alu=%h tk=%b n=%b z=%b", i, valid_out, aluOut, takenOut, nFlag, zFlag);
        end
    endtask

    initial begin
        clear_in();
        rst_n = 0;
        m = '0;
        test_reset();
        test_alu();
        test_branch();
        test_stall_flush();
        test_pcreg_wrap();
        test_bubble();
        test_reset_mid_stall();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register; consumes the ID/EX register outputs.
- Computes the ALU result, keeps the sticky N/Z condition flags, and resolves register-target branches and jumps.
- Registers everything the memory and writeback stages need.
- Supports pipeline stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- DW, 32, datapath width (rs, rt, adder, ALU result, branch target)
- RW, 6, destination register index width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold all registered state this cycle
flush  in  1  load a bubble this cycle
valid_in  in  1  ID/EX slot holds a real instruction
branchN  in  1  branch if N flag set
branchZ  in  1  branch if Z flag set
jump  in  1  unconditional jump to rs
jumpMem  in  1  jump to memory-sourced target (resolved in MEM; passed through)
memRead  in  1  load
memToReg  in  1  writeback selects memory data
memWrite  in  1  store
pcReg  in  1  result is adder (PC-relative save)
aluOp  in  4  ALU operation
regWrt  in  1  register write enable
rd  in  RW  destination register
rs  in  DW  operand A / branch target
rt  in  DW  operand B / store data
adder  in  DW  PC-plus-offset value from ID
valid_out  out  1  EX/MEM slot holds a real instruction
memReadout, memToRegout, memWriteout, jumpMemout, regWrtout  out  1 each  registered controls
rdOut  out  RW  registered destination
aluOut  out  DW  registered result
rtOut  out  DW  registered store data
rsOut  out  DW  registered rs (address for jumpMem)
takenOut  out  1  registered branch/jump redirect
targetOut  out  DW  registered redirect target
nFlag  out  1  sticky negative flag
zFlag  out  1  sticky zero flag

Behaviour:
- Reset (rst_n low, asynchronous) clears every output and both flags to 0 and holds them there. Release takes effect at the next clk edge.
- Edge priority, highest first: reset > stall > flush > load.
- Stall holds all outputs and flags unchanged, even if flush is also high. The hazard unit re-asserts flush after the stall.
- Flush (no stall) loads a bubble: valid_out=0, all control outputs and takenOut 0, all data outputs 0. Flags are unchanged.
- Load (no stall, no flush): all outputs are registered from the inputs. Latency is one cycle. If valid_in=0, the load behaves exactly as a flush.
- ALU result, modulo 2^DW, unsigned wrap:
  - 0 pass rs
  - 1 rs+rt
  - 2 rs-rt
  - 3 -rs (two's complement)
  - 4 rs&rt
  - 5 rs|rt
  - 6 rs^rt
  - 7 pass rt
  - 8..15 give 0
- If pcReg=1, aluOut=adder regardless of aluOp.
- Flags update only on a load with valid_in=1, pcReg=0 and aluOp in 1..6:
  - N = bit DW-1 of the result
  - Z = (result==0)
- Any other case leaves the flags unchanged.
- Branch resolution uses the flag values before this cycle's update.
  - taken = valid_in & (jump | (branchZ & zFlag) | (branchN & nFlag)).
  - targetOut = rs when taken, else 0.
  - jumpMem never sets takenOut; it is only registered to jumpMemout.
- Simultaneous branch and flag-setting op in one instruction: the branch uses the old flags and the new flags are then stored.
- Reset mid-stall discards the held instruction.

Test Plan:
- Reset: rst_n=0 with random inputs, then release → all outputs and flags 0; the first load appears one edge later.
- ADD: aluOp=1, rs=0x7FFFFFFF, rt=1, valid_in=1 → next cycle aluOut=0x80000000, nFlag=1, zFlag=0. Then aluOp=2, rs=rt=5 → aluOut=0, zFlag=1, nFlag=0.
- Branch: zFlag=1, branchZ=1, rs=0x40 → takenOut=1, targetOut=0x40. Same instruction with zFlag=0 → takenOut=0, targetOut=0. jump=1 with rs=0x10 → takenOut=1, targetOut=0x10 regardless of flags.
- Stall/flush: load an ADD, assert stall for 2 cycles with new inputs → outputs frozen. stall+flush together → frozen. flush alone → valid_out=0, regWrtout=0, aluOut=0, flags kept.
- pcReg/wrap: pcReg=1, adder=0x1234, aluOp=1 → aluOut=0x1234, flags unchanged. aluOp=1, rs=0xFFFFFFFF, rt=1 → aluOut=0, zFlag=1.
- valid_in=0 with regWrt=1, jump=1 → bubble: valid_out=0, regWrtout=0, takenOut=0.
